// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-port round-robin arbiter and sequencer for a shared 16-bit word memory
module mem_arbiter #(
   parameter int ADDR_WIDTH = 16,
   parameter int DATA_WIDTH = 16,
   parameter int MEM_DEPTH  = 1024
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  a_req,
   input  logic                  a_we,
   input  logic [ADDR_WIDTH-1:0] a_addr,
   input  logic [DATA_WIDTH-1:0] a_wdata,
   output logic                  a_done,
   output logic                  a_err,
   output logic [DATA_WIDTH-1:0] a_rdata,
   input  logic                  b_req,
   input  logic                  b_we,
   input  logic [ADDR_WIDTH-1:0] b_addr,
   input  logic [DATA_WIDTH-1:0] b_wdata,
   output logic                  b_done,
   output logic                  b_err,
   output logic [DATA_WIDTH-1:0] b_rdata,
   output logic [ADDR_WIDTH-1:0] mem_address,
   output logic                  mem_wr_en,
   output logic [DATA_WIDTH-1:0] mem_data_in,
   input  logic [DATA_WIDTH-1:0] mem_data_out
);

   typedef enum logic {S_IDLE, S_SERVE} state_t;

   // Highest byte address at which a whole word still fits in memory.
   localparam logic [ADDR_WIDTH-1:0] LP_LAST_WORD = ADDR_WIDTH'(MEM_DEPTH - 2);

   state_t                r_state;
   state_t                w_next_state;
   logic                  r_last_b;
   logic                  r_sel_b;
   logic                  r_we;
   logic [ADDR_WIDTH-1:0] r_addr;
   logic [DATA_WIDTH-1:0] r_wdata;
   logic                  r_a_done;
   logic                  r_a_err;
   logic [DATA_WIDTH-1:0] r_a_rdata;
   logic                  r_b_done;
   logic                  r_b_err;
   logic [DATA_WIDTH-1:0] r_b_rdata;
   logic                  w_accept;
   logic                  w_pick_b;
   logic                  w_in_range;

   // Arbitration, next state and memory bus drive (bus is idle-zero outside SERVE)
   always_comb begin
      w_next_state = r_state;
      w_accept     = 1'b0;
      w_pick_b     = 1'b0;
      mem_address  = '0;
      mem_wr_en    = 1'b0;
      mem_data_in  = '0;
      w_in_range   = (r_addr <= LP_LAST_WORD);
      case (r_state)
         S_IDLE: begin
            if (a_req || b_req) begin
               w_accept     = 1'b1;
               // B wins when alone, or on a tie when A was granted last.
               w_pick_b     = b_req && (!a_req || !r_last_b);
               w_next_state = S_SERVE;
            end
         end
         S_SERVE: begin
            mem_address  = r_addr;
            mem_data_in  = r_wdata;
            // A reset arriving during SERVE must keep the write from landing.
            mem_wr_en    = r_we && w_in_range && !reset;
            w_next_state = S_IDLE;
         end
         default: w_next_state = S_IDLE;
      endcase
   end

   // State register, grant history and transaction latch
   always_ff @(posedge clock) begin
      if (reset) begin
         r_state  <= S_IDLE;
         r_last_b <= 1'b1;
         r_sel_b  <= 1'b0;
         r_we     <= 1'b0;
         r_addr   <= '0;
         r_wdata  <= '0;
      end else begin
         r_state <= w_next_state;
         if (w_accept) begin
            r_last_b <= w_pick_b;
            r_sel_b  <= w_pick_b;
            r_we     <= w_pick_b ? b_we    : a_we;
            r_addr   <= w_pick_b ? b_addr  : a_addr;
            r_wdata  <= w_pick_b ? b_wdata : a_wdata;
         end
      end
   end

   // Completion: one-cycle done/err pulse to the winner, read data capture
   always_ff @(posedge clock) begin
      if (reset) begin
         r_a_done  <= 1'b0;
         r_a_err   <= 1'b0;
         r_a_rdata <= '0;
         r_b_done  <= 1'b0;
         r_b_err   <= 1'b0;
         r_b_rdata <= '0;
      end else begin
         r_a_done <= 1'b0;
         r_a_err  <= 1'b0;
         r_b_done <= 1'b0;
         r_b_err  <= 1'b0;
         if (r_state == S_SERVE) begin
            if (r_sel_b) begin
               r_b_done <= 1'b1;
               r_b_err  <= !w_in_range;
               if (!r_we && w_in_range) r_b_rdata <= mem_data_out;
            end else begin
               r_a_done <= 1'b1;
               r_a_err  <= !w_in_range;
               if (!r_we && w_in_range) r_a_rdata <= mem_data_out;
            end
         end
      end
   end

   assign a_done  = r_a_done;
   assign a_err   = r_a_err;
   assign a_rdata = r_a_rdata;
   assign b_done  = r_b_done;
   assign b_err   = r_b_err;
   assign b_rdata = r_b_rdata;

endmodule
